// File: rtl/nn_stream_pkg.sv
// Shared definitions for the neuron output stream stages.
package nn_stream_pkg;

    localparam int NN_DATA_W = 16;
    localparam int NN_IDX_W  = 8;

    typedef enum logic [1:0] {
        RST_WAIT = 2'd0,
        ACCUM    = 2'd1,
        EMIT     = 2'd2
    } state_t;

    // Bit positions inside the result tuser field
    localparam int TUSER_OVF   = 0;
    localparam int TUSER_EMPTY = 1;

    // Most-negative two's-complement score for a given width (sign bit only).
    // Callers truncate the result to their own score width.
    function automatic logic [63:0] most_neg_score(input int width);
        return 64'(1) << (width - 1);
    endfunction

endpackage

// File: rtl/argmax_cmp.sv
// Signed compare/select of a candidate {score, index} against the current best.
module argmax_cmp
    import nn_stream_pkg::*;
#(
    parameter int DATA_W = NN_DATA_W,
    parameter int IDX_W  = NN_IDX_W
) (
    input  logic signed [DATA_W-1:0] cand_score,
    input  logic        [IDX_W-1:0]  cand_idx,
    input  logic signed [DATA_W-1:0] cur_score,
    input  logic        [IDX_W-1:0]  cur_idx,
    input  logic                     force_take,
    output logic        [DATA_W-1:0] sel_score,
    output logic        [IDX_W-1:0]  sel_idx
);

    logic take;

    // Strict greater-than so ties keep the earlier (lower) index
    always_comb begin
        take      = force_take || (cand_score > cur_score);
        sel_score = take ? cand_score : cur_score;
        sel_idx   = take ? cand_idx   : cur_idx;
    end

endmodule

// File: rtl/neuron_argmax.sv
// Running argmax over one neuron-score packet; emits a single-beat result.
module neuron_argmax
    import nn_stream_pkg::*;
#(
    parameter int DATA_W = NN_DATA_W,
    parameter int IDX_W  = NN_IDX_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [DATA_W-1:0]       s_axis_tdata,
    input  logic                    s_axis_tkeep,
    input  logic                    s_axis_tvalid,
    input  logic                    s_axis_tlast,
    output logic                    s_axis_tready,
    output logic [DATA_W+IDX_W-1:0] m_axis_tdata,
    output logic [1:0]              m_axis_tuser,
    output logic                    m_axis_tkeep,
    output logic                    m_axis_tvalid,
    output logic                    m_axis_tlast,
    input  logic                    m_axis_tready
);

    localparam logic [DATA_W-1:0] MOST_NEG = DATA_W'(most_neg_score(DATA_W));
    // Counter value once every index has been used; further scored beats overflow
    localparam logic [IDX_W:0]    CNT_FULL = {1'b1, {IDX_W{1'b0}}};

    state_t                    state_reg, state_next;
    logic [IDX_W:0]            cnt_reg, cnt_next;
    logic [DATA_W-1:0]         max_score_reg, max_score_next;
    logic [IDX_W-1:0]          max_idx_reg, max_idx_next;
    logic                      ovf_reg, ovf_next;
    logic                      s_ready_reg, s_ready_next;
    logic                      m_valid_reg, m_valid_next;
    logic [DATA_W+IDX_W-1:0]   m_data_reg, m_data_next;
    logic [1:0]                m_user_reg, m_user_next;

    logic                      beat_ok;
    logic                      scored;
    logic [DATA_W-1:0]         sel_score;
    logic [IDX_W-1:0]          sel_idx;

    assign beat_ok = s_axis_tvalid && s_ready_reg;
    assign scored  = beat_ok && s_axis_tkeep;

    argmax_cmp #(
        .DATA_W (DATA_W),
        .IDX_W  (IDX_W)
    ) u_cmp (
        .cand_score (s_axis_tdata),
        .cand_idx   (cnt_reg[IDX_W-1:0]),
        .cur_score  (max_score_reg),
        .cur_idx    (max_idx_reg),
        .force_take (cnt_reg == '0),
        .sel_score  (sel_score),
        .sel_idx    (sel_idx)
    );

    // Next-state, accumulator update and result capture
    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        max_score_next = max_score_reg;
        max_idx_next   = max_idx_reg;
        ovf_next       = ovf_reg;
        s_ready_next   = s_ready_reg;
        m_valid_next   = m_valid_reg;
        m_data_next    = m_data_reg;
        m_user_next    = m_user_reg;

        unique case (state_reg)
            RST_WAIT: begin
                state_next   = ACCUM;
                s_ready_next = 1'b1;
            end
            ACCUM: begin
                if (scored) begin
                    if (cnt_reg == CNT_FULL) begin
                        ovf_next = 1'b1;
                    end else begin
                        max_score_next = sel_score;
                        max_idx_next   = sel_idx;
                        cnt_next       = cnt_reg + 1'b1;
                    end
                end
                // Result reflects this beat's own update
                if (beat_ok && s_axis_tlast) begin
                    state_next   = EMIT;
                    s_ready_next = 1'b0;
                    m_valid_next = 1'b1;
                    m_user_next  = '0;
                    m_user_next[TUSER_OVF] = ovf_next;
                    if (cnt_next == '0) begin
                        m_data_next = {MOST_NEG, {IDX_W{1'b0}}};
                        m_user_next[TUSER_EMPTY] = 1'b1;
                    end else begin
                        m_data_next = {max_score_next, max_idx_next};
                    end
                end
            end
            EMIT: begin
                if (m_axis_tready) begin
                    state_next   = ACCUM;
                    cnt_next     = '0;
                    ovf_next     = 1'b0;
                    m_valid_next = 1'b0;
                    s_ready_next = 1'b1;
                end
            end
            default: begin
                state_next = RST_WAIT;
            end
        endcase
    end

    // State and output registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= RST_WAIT;
            cnt_reg       <= '0;
            max_score_reg <= '0;
            max_idx_reg   <= '0;
            ovf_reg       <= 1'b0;
            s_ready_reg   <= 1'b0;
            m_valid_reg   <= 1'b0;
            m_data_reg    <= '0;
            m_user_reg    <= '0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            max_score_reg <= max_score_next;
            max_idx_reg   <= max_idx_next;
            ovf_reg       <= ovf_next;
            s_ready_reg   <= s_ready_next;
            m_valid_reg   <= m_valid_next;
            m_data_reg    <= m_data_next;
            m_user_reg    <= m_user_next;
        end
    end

    assign s_axis_tready = s_ready_reg;
    assign m_axis_tvalid = m_valid_reg;
    assign m_axis_tlast  = m_valid_reg;
    assign m_axis_tkeep  = m_valid_reg;
    assign m_axis_tdata  = m_data_reg;
    assign m_axis_tuser  = m_user_reg;

endmodule
